// File: rtl/cutoff_freq_slew_unit.sv
// Multi-channel envelope-to-cutoff mapper with per-channel attack/release slew limiting.
// Three register stages: envelope scale, target mapping, slew and channel-state update.
module cutoff_freq_slew_unit #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CUTOFF_WIDTH = 16,
  parameter int FC_MIN       = 69,
  parameter int FC_MAX       = 1024,
  parameter int ENV_SHIFT    = 20,
  parameter int NUM_CH       = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_channel,
  input  logic [SAMPLE_WIDTH-1:0] env_avg,
  input  logic [3:0]              filter_strength_ratio,
  input  logic [CUTOFF_WIDTH-1:0] attack_step,
  input  logic [CUTOFF_WIDTH-1:0] release_step,
  input  logic                    slew_bypass,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_channel,
  output logic [CUTOFF_WIDTH-1:0] cutoff_freq,
  output logic [CUTOFF_WIDTH-1:0] target_freq
);

  localparam int P_W    = ENV_SHIFT + 4;
  localparam int PROD_W = P_W + CUTOFF_WIDTH;
  localparam logic [SAMPLE_WIDTH-1:0] ENV_MAX  = SAMPLE_WIDTH'((64'd1 << ENV_SHIFT) - 64'd1);
  localparam logic [CUTOFF_WIDTH-1:0] FC_MIN_C = CUTOFF_WIDTH'(FC_MIN);
  localparam logic [PROD_W-1:0]       SPAN_C   = PROD_W'(FC_MAX - FC_MIN);
  localparam logic [31:0]             NUM_CH_U = 32'(NUM_CH);

  // Stage 1 registers
  logic                    v1_d, v1_q;
  logic [CH_W-1:0]         ch1_d, ch1_q;
  logic [P_W-1:0]          p1_d, p1_q;
  logic [CUTOFF_WIDTH-1:0] atk1_d, atk1_q, rel1_d, rel1_q;
  logic                    byp1_d, byp1_q;

  // Stage 2 registers
  logic                    v2_d, v2_q;
  logic [CH_W-1:0]         ch2_d, ch2_q;
  logic [CUTOFF_WIDTH-1:0] tgt2_d, tgt2_q;
  logic [CUTOFF_WIDTH-1:0] atk2_d, atk2_q, rel2_d, rel2_q;
  logic                    byp2_d, byp2_q;

  // Stage 3 / output registers and channel state
  logic                    out_valid_d, out_valid_q;
  logic [CH_W-1:0]         out_channel_d, out_channel_q;
  logic [CUTOFF_WIDTH-1:0] cutoff_d, cutoff_q;
  logic [CUTOFF_WIDTH-1:0] target_d, target_q;
  logic [CUTOFF_WIDTH-1:0] state_d [NUM_CH];
  logic [CUTOFF_WIDTH-1:0] state_q [NUM_CH];

  logic [ENV_SHIFT-1:0]    envc;
  logic [PROD_W-1:0]       prod;
  logic [CUTOFF_WIDTH-1:0] cur, diff, lim, nxt;

  always_comb begin
    envc   = (env_avg > ENV_MAX) ? ENV_MAX[ENV_SHIFT-1:0] : env_avg[ENV_SHIFT-1:0];
    v1_d   = in_valid && (32'(in_channel) < NUM_CH_U);
    ch1_d  = in_channel;
    p1_d   = P_W'(envc) * P_W'(filter_strength_ratio);
    atk1_d = attack_step;
    rel1_d = release_step;
    byp1_d = slew_bypass;
  end

  // Scaling by 2^(ENV_SHIFT+4) rather than 15*2^ENV_SHIFT keeps the target strictly below FC_MAX.
  always_comb begin
    prod   = PROD_W'(p1_q) * SPAN_C;
    v2_d   = v1_q;
    ch2_d  = ch1_q;
    tgt2_d = FC_MIN_C + CUTOFF_WIDTH'(prod >> P_W);
    atk2_d = atk1_q;
    rel2_d = rel1_q;
    byp2_d = byp1_q;
  end

  // A zero step means the move is unlimited; the limit is clamped to the distance so it never overshoots.
  always_comb begin
    cur  = state_q[ch2_q];
    diff = '0;
    lim  = '0;
    nxt  = tgt2_q;
    if (!byp2_q && (tgt2_q > cur)) begin
      diff = tgt2_q - cur;
      lim  = ((atk2_q != '0) && (atk2_q < diff)) ? atk2_q : diff;
      nxt  = cur + lim;
    end else if (!byp2_q && (tgt2_q < cur)) begin
      diff = cur - tgt2_q;
      lim  = ((rel2_q != '0) && (rel2_q < diff)) ? rel2_q : diff;
      nxt  = cur - lim;
    end

    state_d       = state_q;
    out_valid_d   = v2_q;
    out_channel_d = out_channel_q;
    cutoff_d      = cutoff_q;
    target_d      = target_q;
    if (v2_q) begin
      state_d[ch2_q] = nxt;
      out_channel_d  = ch2_q;
      cutoff_d       = nxt;
      target_d       = tgt2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      cutoff_q      <= FC_MIN_C;
      target_q      <= FC_MIN_C;
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= FC_MIN_C;
    end else begin
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      cutoff_q      <= cutoff_d;
      target_q      <= target_d;
      state_q       <= state_d;
    end
  end

  // Payload flops carry no reset; their valid bits gate every use.
  always_ff @(posedge clk) begin
    ch1_q  <= ch1_d;
    p1_q   <= p1_d;
    atk1_q <= atk1_d;
    rel1_q <= rel1_d;
    byp1_q <= byp1_d;
    ch2_q  <= ch2_d;
    tgt2_q <= tgt2_d;
    atk2_q <= atk2_d;
    rel2_q <= rel2_d;
    byp2_q <= byp2_d;
  end

  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign cutoff_freq = cutoff_q;
  assign target_freq = target_q;

endmodule

// File: tb/tb_cutoff_freq_slew_unit.sv
// Scoreboard bench for cutoff_freq_slew_unit: a 2-channel and a 3-channel instance share stimulus.
module tb_cutoff_freq_slew_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [1:0]  tb_ch = '0;
  logic [23:0] env = '0;
  logic [3:0]  str = '0;
  logic [15:0] atk = '0, rel = '0;
  logic        byp = 1'b0;

  logic        ov_a, ov_b;
  logic [0:0]  och_a;
  logic [1:0]  och_b;
  logic [15:0] cut_a, tgt_a, cut_b, tgt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] cut;
    logic [15:0] tgt;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cutoff_freq_slew_unit #(.NUM_CH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_channel(tb_ch[0:0]),
    .env_avg(env), .filter_strength_ratio(str), .attack_step(atk), .release_step(rel),
    .slew_bypass(byp), .out_valid(ov_a), .out_channel(och_a),
    .cutoff_freq(cut_a), .target_freq(tgt_a)
  );

  cutoff_freq_slew_unit #(.NUM_CH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_channel(tb_ch),
    .env_avg(env), .filter_strength_ratio(str), .attack_step(atk), .release_step(rel),
    .slew_bypass(byp), .out_valid(ov_b), .out_channel(och_b),
    .cutoff_freq(cut_b), .target_freq(tgt_b)
  );

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov_a === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_a: cyc=%0d ch=%0d cut=%0d tgt=%0d, required no output", cyc, och_a, cut_a, tgt_a);
        end else begin
          e = qa.pop_front();
          if ({1'b0, och_a} != e.ch || cut_a != e.cut || tgt_a != e.tgt || cyc != e.due)
            begin
              errors++;
              $display("FAIL result_a: got cyc=%0d ch=%0d cut=%0d tgt=%0d, required cyc=%0d ch=%0d cut=%0d tgt=%0d",
                       cyc, och_a, cut_a, tgt_a, e.due, e.ch, e.cut, e.tgt);
            end
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov_b === 1'b1) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_b: cyc=%0d ch=%0d cut=%0d tgt=%0d, required no output", cyc, och_b, cut_b, tgt_b);
        end else begin
          e = qb.pop_front();
          if (och_b != e.ch || cut_b != e.cut || tgt_b != e.tgt || cyc != e.due) begin
            errors++;
            $display("FAIL result_b: got cyc=%0d ch=%0d cut=%0d tgt=%0d, required cyc=%0d ch=%0d cut=%0d tgt=%0d",
                     cyc, och_b, cut_b, tgt_b, e.due, e.ch, e.cut, e.tgt);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One sample on the next negedge; b selects dut_b. Expected result is due 3 cycles later.
  task automatic drive(input logic b, input logic [1:0] ch, input logic [23:0] e_in,
                       input logic [3:0] s_in, input logic [15:0] a_in, input logic [15:0] r_in,
                       input logic by_in, input logic push, input int ecut, input int etgt);
    exp_t x;
    @(negedge clk);
    valid_a = !b; valid_b = b; tb_ch = ch; env = e_in; str = s_in;
    atk = a_in; rel = r_in; byp = by_in;
    if (push) begin
      x.ch = ch; x.cut = 16'(ecut); x.tgt = 16'(etgt); x.due = cyc + 3;
      if (b) qb.push_back(x); else qa.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_a = 1'b0; valid_b = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v;
    // Power-on reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", int'(ov_a), 0);
    chk("reset_out_channel", int'(och_a), 0);
    chk("reset_cutoff", int'(cut_a), 69);
    chk("reset_target", int'(tgt_a), 69);
    rst_n = 1'b1;

    // Target mapping through bypass
    drive(0, 0, 24'd0,        4'd0,  16'd0, 16'd0, 1, 1, 69,  69);
    drive(0, 0, 24'd524288,   4'd8,  16'd0, 16'd0, 1, 1, 307, 307);
    drive(0, 0, 24'd1048575,  4'd15, 16'd0, 16'd0, 1, 1, 964, 964);
    drive(0, 0, 24'd16777215, 4'd15, 16'd0, 16'd0, 1, 1, 964, 964);
    drive(0, 0, 24'd524288,   4'd8,  16'd0, 16'd0, 1, 1, 307, 307);
    idle(5);
    chk("hold_cutoff", int'(cut_a), 307);
    chk("hold_target", int'(tgt_a), 307);

    // Attack slew from reset
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      v = 69 + 64 * k;
      if (v > 964) v = 964;
      drive(0, 0, 24'd1048575, 4'd15, 16'd64, 16'd0, 0, 1, v, 964);
    end

    // Release slew, then unlimited steps both ways
    for (int k = 1; k <= 56; k++) begin
      v = 964 - 16 * k;
      if (v < 69) v = 69;
      drive(0, 0, 24'd0, 4'd0, 16'd0, 16'd16, 0, 1, v, 69);
    end
    drive(0, 0, 24'd1048575, 4'd15, 16'd0, 16'd0, 0, 1, 964, 964);
    drive(0, 0, 24'd0,       4'd0,  16'd0, 16'd0, 0, 1, 69,  69);

    // Channel independence, interleaved
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 24'd1048575, 4'd15, 16'd64, 16'd0, 0, 1, 69 + 64 * k, 964);
      drive(0, 1, 24'd0,       4'd0,  16'd64, 16'd0, 0, 1, 69, 69);
    end

    // Reset while samples are in flight
    idle(5);
    drive(0, 0, 24'd1048575, 4'd15, 16'd64, 16'd0, 0, 0, 0, 0);
    drive(0, 0, 24'd1048575, 4'd15, 16'd64, 16'd0, 0, 0, 0, 0);
    drive(0, 0, 24'd1048575, 4'd15, 16'd64, 16'd0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; valid_a = 1'b0;
    chk("midreset_out_valid", int'(ov_a), 0);
    chk("midreset_cutoff", int'(cut_a), 69);
    chk("midreset_target", int'(tgt_a), 69);
    idle(4);
    drive(0, 0, 24'd1048575, 4'd15, 16'd64, 16'd0, 0, 1, 133, 964);

    // Out-of-range channel on the 3-channel instance
    idle(5);
    drive(1, 0, 24'd1048575, 4'd15, 16'd0, 16'd0, 1, 1, 964, 964);
    drive(1, 1, 24'd524288,  4'd8,  16'd0, 16'd0, 1, 1, 307, 307);
    drive(1, 2, 24'd0,       4'd0,  16'd0, 16'd0, 1, 1, 69,  69);
    drive(1, 3, 24'd1048575, 4'd15, 16'd0, 16'd0, 1, 0, 0, 0);
    drive(1, 3, 24'd0,       4'd0,  16'd0, 16'd0, 1, 0, 0, 0);
    idle(4);
    drive(1, 0, 24'd1048575, 4'd15, 16'd1, 16'd1, 0, 1, 964, 964);
    drive(1, 1, 24'd1048575, 4'd15, 16'd1, 16'd1, 0, 1, 308, 964);
    drive(1, 2, 24'd1048575, 4'd15, 16'd1, 16'd1, 0, 1, 70,  964);

    idle(8);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
